// File: rtl/z3_slave_sequencer.sv
// Zorro III slave cycle sequencer: runs one claimed card/autoconfig access per full cycle,
// driving the local target handshake, DTACK, SLAVE and the data-buffer enable.
module z3_slave_sequencer #(
    parameter int unsigned CFG_WAIT = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       IORST_n,
    input  logic       Z_FCS_n,
    input  logic       DOE,
    input  logic [3:0] DS_n,
    input  logic       READ,
    input  logic       config_cycle,
    input  logic       card_cycle,
    input  logic       tgt_ack,
    output logic       tgt_req,
    output logic       tgt_we,
    output logic [3:0] tgt_be,
    output logic       slave,
    output logic       d_oe,
    output logic       dtack,
    output logic       timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StStrobe,
        StCfgWait,
        StTgtWait,
        StAck,
        StAbort
    } state_e;

    localparam logic [3:0] CfgLoad   = 4'((CFG_WAIT > 0) ? (CFG_WAIT - 1) : 0);
    localparam logic [7:0] TimerLast = 8'(TIMEOUT - 2);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] timer_q, timer_d;
    logic       card_q, card_d;
    logic       req_q, req_d;
    logic       we_q, we_d;
    logic [3:0] be_q, be_d;
    logic       slave_q, slave_d;
    logic       d_oe_q, d_oe_d;
    logic       dtack_q, dtack_d;
    logic       timeout_q, timeout_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q;
        card_d    = card_q;
        req_d     = req_q;
        we_d      = we_q;
        be_d      = be_q;
        slave_d   = slave_q;
        d_oe_d    = d_oe_q;
        dtack_d   = dtack_q;
        timeout_d = 1'b0;

        // End of the full cycle overrides everything outside IDLE.
        if (state_q != StIdle && Z_FCS_n) begin
            state_d = StIdle;
            req_d   = 1'b0;
            we_d    = 1'b0;
            be_d    = 4'h0;
            slave_d = 1'b0;
            d_oe_d  = 1'b0;
            dtack_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (card_cycle || config_cycle) begin
                        state_d = StStrobe;
                        slave_d = 1'b1;
                        card_d  = card_cycle;
                    end
                end
                StStrobe: begin
                    if (DOE && DS_n != 4'hF) begin
                        we_d = !READ;
                        be_d = ~DS_n;
                        if (card_q) begin
                            state_d = StTgtWait;
                            req_d   = 1'b1;
                            timer_d = 8'd0;
                        end else begin
                            d_oe_d = READ;
                            if (CFG_WAIT == 0) begin
                                state_d = StAck;
                                dtack_d = 1'b1;
                            end else begin
                                state_d = StCfgWait;
                                cnt_d   = CfgLoad;
                            end
                        end
                    end
                end
                StCfgWait: begin
                    if (cnt_q == 4'd0) begin
                        state_d = StAck;
                        dtack_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                StTgtWait: begin
                    if (tgt_ack) begin
                        state_d = StAck;
                        dtack_d = 1'b1;
                        req_d   = 1'b0;
                        d_oe_d  = READ;
                    end else if (timer_q == TimerLast) begin
                        // Host recovers via the system bus timeout; no DTACK is given.
                        state_d   = StAbort;
                        req_d     = 1'b0;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
                StAck:   ;
                StAbort: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge IORST_n) begin
        if (!IORST_n) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            timer_q   <= 8'd0;
            card_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 4'h0;
            slave_q   <= 1'b0;
            d_oe_q    <= 1'b0;
            dtack_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            card_q    <= card_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            slave_q   <= slave_d;
            d_oe_q    <= d_oe_d;
            dtack_q   <= dtack_d;
            timeout_q <= timeout_d;
        end
    end

    assign tgt_req = req_q;
    assign tgt_we  = we_q;
    assign tgt_be  = be_q;
    assign slave   = slave_q;
    assign d_oe    = d_oe_q;
    assign dtack   = dtack_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_z3_slave_sequencer.sv
// Scoreboard bench for z3_slave_sequencer (CFG_WAIT = 2, TIMEOUT = 8).
module tb_z3_slave_sequencer;

    logic       clk = 1'b0;
    logic       IORST_n;
    logic       Z_FCS_n;
    logic       DOE;
    logic [3:0] DS_n;
    logic       READ;
    logic       config_cycle;
    logic       card_cycle;
    logic       tgt_ack;
    logic       tgt_req;
    logic       tgt_we;
    logic [3:0] tgt_be;
    logic       slave;
    logic       d_oe;
    logic       dtack;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    z3_slave_sequencer #(
        .CFG_WAIT (2),
        .TIMEOUT  (8)
    ) dut (
        .clk          (clk),
        .IORST_n      (IORST_n),
        .Z_FCS_n      (Z_FCS_n),
        .DOE          (DOE),
        .DS_n         (DS_n),
        .READ         (READ),
        .config_cycle (config_cycle),
        .card_cycle   (card_cycle),
        .tgt_ack      (tgt_ack),
        .tgt_req      (tgt_req),
        .tgt_we       (tgt_we),
        .tgt_be       (tgt_be),
        .slave        (slave),
        .d_oe         (d_oe),
        .dtack        (dtack),
        .timeout      (timeout)
    );

    // Output vector: {req, we, be[3:0], slave, d_oe, dtack, timeout}
    function automatic logic [9:0] outv();
        return {tgt_req, tgt_we, tgt_be, slave, d_oe, dtack, timeout};
    endfunction

    function automatic logic [9:0] ex(logic req, logic we, logic [3:0] be, logic sl,
                                      logic oe, logic dt, logic to);
        return {req, we, be, sl, oe, dt, to};
    endfunction

    task automatic check(string tag, logic [9:0] got, logic [9:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (req we be sl oe dt to)", tag, got, exp);
        end
    endtask

    task automatic drv(logic fcs, logic doe, logic [3:0] ds, logic rd, logic cfg, logic crd,
                       logic ack);
        Z_FCS_n      = fcs;
        DOE          = doe;
        DS_n         = ds;
        READ         = rd;
        config_cycle = cfg;
        card_cycle   = crd;
        tgt_ack      = ack;
    endtask

    // Expected value is queued with the stimulus, retired after the following edge.
    task automatic step(string tag, logic [9:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check(tag_q.pop_front(), outv(), exp_q.pop_front());
        @(negedge clk);
    endtask

    localparam logic [9:0] Zero = 10'b0;

    initial begin
        IORST_n = 1'b0;
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("reset_outputs", outv(), Zero);
        @(negedge clk);
        @(negedge clk);
        IORST_n = 1'b1;
        step("idle_after_reset", Zero);

        // Config read
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cfg_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b0);
        step("cfg_n", ex(0, 0, 4'h8, 1, 1, 0, 0));
        step("cfg_n1", ex(0, 0, 4'h8, 1, 1, 0, 0));
        step("cfg_n2_dtack", ex(0, 0, 4'h8, 1, 1, 1, 0));
        step("cfg_hold", ex(0, 0, 4'h8, 1, 1, 1, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("cfg_release", Zero);
        step("cfg_idle", Zero);

        // Card write, DS_n = 0011
        drv(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        step("wr_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0);
        step("wr_n", ex(1, 1, 4'hC, 1, 0, 0, 0));
        step("wr_n1", ex(1, 1, 4'hC, 1, 0, 0, 0));
        step("wr_n2", ex(1, 1, 4'hC, 1, 0, 0, 0));
        tgt_ack = 1'b1;
        step("wr_n3_ack", ex(0, 1, 4'hC, 1, 0, 1, 0));
        tgt_ack = 1'b0;
        DS_n    = 4'h0;  // second DS pattern in the same FCS is ignored
        step("wr_hold", ex(0, 1, 4'hC, 1, 0, 1, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wr_release", Zero);

        // Card read, no ack: timeout
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        step("to_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("to_n", ex(1, 0, 4'hF, 1, 0, 0, 0));
        for (int i = 1; i <= 6; i++) step($sformatf("to_wait%0d", i), ex(1, 0, 4'hF, 1, 0, 0, 0));
        step("to_pulse", ex(0, 0, 4'hF, 1, 0, 0, 1));
        step("to_after", ex(0, 0, 4'hF, 1, 0, 0, 0));
        tgt_ack = 1'b1;  // late ack after abort has no effect
        step("to_hold", ex(0, 0, 4'hF, 1, 0, 0, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("to_release", Zero);

        // Card read, ack exactly at N+7 wins over timeout
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        step("ak_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        step("ak_n", ex(1, 0, 4'hF, 1, 0, 0, 0));
        for (int i = 1; i <= 6; i++) step($sformatf("ak_wait%0d", i), ex(1, 0, 4'hF, 1, 0, 0, 0));
        tgt_ack = 1'b1;
        step("ak_n7", ex(0, 0, 4'hF, 1, 1, 1, 0));
        tgt_ack = 1'b0;
        step("ak_hold", ex(0, 0, 4'hF, 1, 1, 1, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("ak_release", Zero);

        // Cycle end while waiting on the target
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mid_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0);
        step("mid_n", ex(1, 0, 4'hA, 1, 0, 0, 0));
        step("mid_n1", ex(1, 0, 4'hA, 1, 0, 0, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mid_abort", Zero);
        for (int i = 0; i < 8; i++) step($sformatf("mid_quiet%0d", i), Zero);

        // Reset asserted in ACK
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rst_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1, 1'b0);
        step("rst_n", ex(1, 0, 4'h6, 1, 0, 0, 0));
        tgt_ack = 1'b1;
        step("rst_ack", ex(0, 0, 4'h6, 1, 1, 1, 0));
        IORST_n = 1'b0;
        #1;
        check("rst_async", outv(), Zero);
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        IORST_n = 1'b1;
        drv(1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rst2_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1, 1'b0);
        step("rst2_n", ex(1, 1, 4'h1, 1, 0, 0, 0));
        tgt_ack = 1'b1;
        step("rst2_ack", ex(0, 1, 4'h1, 1, 0, 1, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rst2_release", Zero);

        // Card and config both claimed: card wins
        drv(1'b0, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        step("both_claim", ex(0, 0, 4'h0, 1, 0, 0, 0));
        drv(1'b0, 1'b1, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0);
        step("both_n", ex(1, 0, 4'h1, 1, 0, 0, 0));
        step("both_n1", ex(1, 0, 4'h1, 1, 0, 0, 0));
        tgt_ack = 1'b1;
        step("both_ack", ex(0, 0, 4'h1, 1, 1, 1, 0));
        drv(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0);
        step("both_release", Zero);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
